// File: rtl/render_scheduler_pkg.sv
// Shared widths, screen geometry, FSM encodings and command bundle
// for the page renderer's drawing scheduler.
package render_scheduler_pkg;

   localparam int COLOR_W   = 3;
   localparam int X_W       = 8;
   localparam int Y_W       = 7;
   localparam int CHAR_W    = 8;
   localparam int SIZE_W    = 3;
   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int GLYPH_DIM = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECT    = 3'd1,
      G_FETCH = 3'd2,
      G_WAIT  = 3'd3,
      G_EMIT  = 3'd4
   } state_t;

   typedef struct packed {
      logic [COLOR_W-1:0] color;
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [X_W-1:0]     w;
      logic [Y_W-1:0]     h;
      logic [CHAR_W-1:0]  ch;
      logic [SIZE_W-1:0]  size;
   } cmd_t;

   function automatic logic on_screen(
      input logic [X_W:0] x,
      input logic [Y_W:0] y
   );
      return (x < (X_W+1)'(SCREEN_W)) &&
             (y < (Y_W+1)'(SCREEN_H));
   endfunction

endpackage

// File: rtl/render_scheduler_if.sv
// Command, font ROM and pixel-write signals of the scheduler.
// slave is the scheduler's view, master the environment's.
interface render_scheduler_if;
   import render_scheduler_pkg::*;

   logic               txt_req;
   logic               txt_ack;
   logic [CHAR_W-1:0]  txt_char;
   logic [COLOR_W-1:0] txt_color;
   logic [SIZE_W-1:0]  txt_size;
   logic [X_W-1:0]     txt_x;
   logic [Y_W-1:0]     txt_y;

   logic               blk_req;
   logic               blk_ack;
   logic [COLOR_W-1:0] blk_color;
   logic [X_W-1:0]     blk_x;
   logic [Y_W-1:0]     blk_y;
   logic [X_W-1:0]     blk_w;
   logic [Y_W-1:0]     blk_h;

   logic [CHAR_W+2:0]  font_addr;
   logic [7:0]         font_data;

   logic               pix_valid;
   logic               pix_ready;
   logic [X_W-1:0]     pix_x;
   logic [Y_W-1:0]     pix_y;
   logic [COLOR_W-1:0] pix_color;
   logic               busy;

   modport slave (
      input  txt_req, txt_char, txt_color, txt_size, txt_x, txt_y,
      output txt_ack,
      input  blk_req, blk_color, blk_x, blk_y, blk_w, blk_h,
      output blk_ack,
      output font_addr,
      input  font_data,
      output pix_valid, pix_x, pix_y, pix_color,
      input  pix_ready,
      output busy
   );

   modport master (
      output txt_req, txt_char, txt_color, txt_size, txt_x, txt_y,
      input  txt_ack,
      output blk_req, blk_color, blk_x, blk_y, blk_w, blk_h,
      input  blk_ack,
      input  font_addr,
      output font_data,
      input  pix_valid, pix_x, pix_y, pix_color,
      output pix_ready,
      input  busy
   );

endinterface

// File: rtl/render_scheduler_span_walker.sv
// Two-level counter: inner index sweeps 0..inner_n-1 per outer step.
// Wraps to (0,0) after the last position so it can be reused.
module render_scheduler_span_walker #(
   parameter int OW = 7,
   parameter int IW = 8
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          load,
   input  logic          adv,
   input  logic [OW-1:0] outer_n,
   input  logic [IW-1:0] inner_n,
   output logic [OW-1:0] outer_i,
   output logic [IW-1:0] inner_i,
   output logic          done
);

   localparam logic [OW-1:0] OONE = 1;
   localparam logic [IW-1:0] IONE = 1;

   logic [OW-1:0] o_cnt;
   logic [IW-1:0] i_cnt;
   logic          o_end;
   logic          i_end;

   assign o_end = outer_i == o_cnt - OONE;
   assign i_end = inner_i == i_cnt - IONE;
   assign done  = o_end & i_end;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         o_cnt   <= '0;
         i_cnt   <= '0;
         outer_i <= '0;
         inner_i <= '0;
      end else if (load) begin
         o_cnt   <= outer_n;
         i_cnt   <= inner_n;
         outer_i <= '0;
         inner_i <= '0;
      end else if (adv) begin
         if (i_end) begin
            inner_i <= '0;
            outer_i <= o_end ? '0 : outer_i + OONE;
         end else begin
            inner_i <= inner_i + IONE;
         end
      end
   end

endmodule

// File: rtl/render_scheduler.sv
// Round-robin text/block arbiter and rasteriser onto a single
// framebuffer pixel-write port, with glyph rows from the font ROM.
module render_scheduler
   import render_scheduler_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   render_scheduler_if.slave bus
);

   state_t            state;
   cmd_t              cmd;
   logic              prefer_txt;
   logic [2:0]        col;
   logic [2:0]        row;
   logic [7:0]        bits;
   logic              txt_ack_q;
   logic              blk_ack_q;

   logic              any_req;
   logic              pick_blk;
   logic              load;
   logic              rect_mode;
   logic              emit_mode;
   logic              empty;
   logic              valid;
   logic              step;
   logic              wdone;
   logic [SIZE_W-1:0] tsize;
   logic [Y_W-1:0]    outer_n;
   logic [Y_W-1:0]    outer_i;
   logic [X_W-1:0]    inner_n;
   logic [X_W-1:0]    inner_i;
   logic [X_W:0]      cx;
   logic [Y_W:0]      cy;

   assign tsize    = (bus.txt_size == '0) ? SIZE_W'(1) : bus.txt_size;
   assign any_req  = bus.txt_req | bus.blk_req;
   assign pick_blk = bus.blk_req & (~bus.txt_req | ~prefer_txt);
   assign load     = (state == IDLE) & any_req;
   assign outer_n  = pick_blk ? bus.blk_h : Y_W'(tsize);
   assign inner_n  = pick_blk ? bus.blk_w : X_W'(tsize);

   render_scheduler_span_walker #(
      .OW(Y_W),
      .IW(X_W)
   ) u_span_walker (
      .clock   (clock),
      .resetn  (resetn),
      .load    (load),
      .adv     (step),
      .outer_n (outer_n),
      .inner_n (inner_n),
      .outer_i (outer_i),
      .inner_i (inner_i),
      .done    (wdone)
   );

   // One bit wider than the ports so clipped positions never wrap
   always_comb begin
      cx = {1'b0, cmd.x} + {1'b0, inner_i};
      cy = {1'b0, cmd.y} + {1'b0, outer_i};
      if (emit_mode) begin
         cx = cx + (X_W+1)'(col) * (X_W+1)'(cmd.size);
         cy = cy + (Y_W+1)'(row) * (Y_W+1)'(cmd.size);
      end
   end

   assign rect_mode = state == RECT;
   assign emit_mode = state == G_EMIT;
   assign empty     = (cmd.w == '0) | (cmd.h == '0);
   assign valid     = on_screen(cx, cy) &
                      ((rect_mode & ~empty) | (emit_mode & bits[~col]));
   assign step      = (rect_mode | emit_mode) & (~valid | bus.pix_ready);

   assign bus.pix_valid = valid;
   assign bus.pix_x     = cx[X_W-1:0];
   assign bus.pix_y     = cy[Y_W-1:0];
   assign bus.pix_color = cmd.color;
   assign bus.font_addr = {cmd.ch, row};
   assign bus.txt_ack   = txt_ack_q;
   assign bus.blk_ack   = blk_ack_q;
   assign bus.busy      = state != IDLE;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cmd        <= '0;
         prefer_txt <= 1'b0;
         col        <= '0;
         row        <= '0;
         bits       <= '0;
         txt_ack_q  <= 1'b0;
         blk_ack_q  <= 1'b0;
      end else begin
         txt_ack_q <= 1'b0;
         blk_ack_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req && pick_blk) begin
                  cmd.color  <= bus.blk_color;
                  cmd.x      <= bus.blk_x;
                  cmd.y      <= bus.blk_y;
                  cmd.w      <= bus.blk_w;
                  cmd.h      <= bus.blk_h;
                  cmd.ch     <= '0;
                  cmd.size   <= SIZE_W'(1);
                  blk_ack_q  <= 1'b1;
                  prefer_txt <= 1'b1;
                  state      <= RECT;
               end else if (any_req) begin
                  cmd.color  <= bus.txt_color;
                  cmd.x      <= bus.txt_x;
                  cmd.y      <= bus.txt_y;
                  cmd.w      <= '0;
                  cmd.h      <= '0;
                  cmd.ch     <= bus.txt_char;
                  cmd.size   <= tsize;
                  txt_ack_q  <= 1'b1;
                  prefer_txt <= 1'b0;
                  col        <= '0;
                  row        <= '0;
                  state      <= G_FETCH;
               end
            end
            RECT: begin
               if (step && (empty || wdone)) state <= IDLE;
            end
            G_FETCH: state <= G_WAIT;
            G_WAIT: begin
               bits  <= bus.font_data;
               state <= G_EMIT;
            end
            G_EMIT: begin
               if (step && wdone) begin
                  col <= col + 3'd1;
                  if (col == 3'(GLYPH_DIM-1)) begin
                     row   <= row + 3'd1;
                     state <= (row == 3'(GLYPH_DIM-1)) ? IDLE : G_FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler with a pixel scoreboard
// and a registered font ROM model.
module tb_render_scheduler;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } px_t;

   logic clock;
   logic resetn;
   int   checks;
   int   errors;
   bit   mon_on;
   bit   rand_ready;
   px_t  sb[$];
   logic [7:0] rom [0:2047];

   render_scheduler_if bus ();

   render_scheduler dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bus.font_data <= rom[bus.font_addr];

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard monitor plus stall-stability check
   initial begin : monitor
      px_t e;
      bit  stalled;
      px_t held;
      stalled = 0;
      held = '0;
      forever begin
         @(negedge clock);
         if (resetn && mon_on) begin
            if (stalled) begin
               checks++;
               if (!bus.pix_valid || bus.pix_x != held.x ||
                   bus.pix_y != held.y || bus.pix_color != held.c) begin
                  errors++;
                  $display("FAIL stall_hold got v%0d (%0d,%0d,c%0d) exp v1 (%0d,%0d,c%0d)",
                           bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color,
                           held.x, held.y, held.c);
               end
            end
            if (bus.pix_valid && bus.pix_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL pix_extra got (%0d,%0d,c%0d) exp none",
                           bus.pix_x, bus.pix_y, bus.pix_color);
               end else begin
                  e = sb.pop_front();
                  if (bus.pix_x != e.x || bus.pix_y != e.y || bus.pix_color != e.c) begin
                     errors++;
                     $display("FAIL pix got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)",
                              bus.pix_x, bus.pix_y, bus.pix_color, e.x, e.y, e.c);
                  end
               end
            end
            stalled = bus.pix_valid && !bus.pix_ready;
            held = {bus.pix_x, bus.pix_y, bus.pix_color};
         end else begin
            stalled = 0;
         end
      end
   end

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int x, input int y, input int c);
      sb.push_back({8'(x), 7'(y), 3'(c)});
   endtask

   task automatic set_blk(input int x, input int y, input int w, input int h, input int c);
      bus.blk_x = 8'(x);
      bus.blk_y = 7'(y);
      bus.blk_w = 8'(w);
      bus.blk_h = 7'(h);
      bus.blk_color = 3'(c);
   endtask

   task automatic set_txt(input int ch, input int s, input int x, input int y, input int c);
      bus.txt_char = 8'(ch);
      bus.txt_size = 3'(s);
      bus.txt_x = 8'(x);
      bus.txt_y = 7'(y);
      bus.txt_color = 3'(c);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (bus.busy && n < 2000) begin
         n++;
         @(negedge clock);
      end
      chk(!bus.busy, {nm, "_idle"}, int'(bus.busy), 0);
   endtask

   // Issue one command, count its busy cycles and ack pulses
   task automatic run(input bit blk, input int exp_busy, input string nm);
      int n;
      int acks;
      bit got;
      got = 0;
      if (blk) bus.blk_req = 1'b1;
      else bus.txt_req = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         got = blk ? bus.blk_ack : bus.txt_ack;
      end
      bus.blk_req = 1'b0;
      bus.txt_req = 1'b0;
      chk(got, {nm, "_ack"}, int'(got), 1);
      n = 0;
      acks = 0;
      while (bus.busy && n < 5000) begin
         n++;
         if (blk ? bus.blk_ack : bus.txt_ack) acks++;
         @(negedge clock);
      end
      if (exp_busy >= 0) chk(n == exp_busy, {nm, "_cycles"}, n, exp_busy);
      chk(acks == 1, {nm, "_ackonce"}, acks, 1);
      @(negedge clock);
      chk(sb.size() == 0, {nm, "_drain"}, sb.size(), 0);
   endtask

   initial begin : stim
      bit got;
      for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
      rom[{8'h41, 3'd0}] = 8'h81;
      for (int r = 0; r < 8; r++) rom[{8'h42, 3'(r)}] = 8'hFF;
      checks = 0;
      errors = 0;
      mon_on = 1;
      rand_ready = 0;
      resetn = 1'b0;
      bus.txt_req = 1'b0;
      bus.blk_req = 1'b0;
      set_blk(0, 0, 0, 0, 0);
      set_txt(0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      chk(bus.pix_valid == 0, "rst_valid", int'(bus.pix_valid), 0);
      chk(bus.busy == 0, "rst_busy", int'(bus.busy), 0);
      chk(bus.font_addr == 0, "rst_font_addr", int'(bus.font_addr), 0);
      @(posedge clock);
      #3 resetn = 1'b1;
      @(negedge clock);
      chk(bus.txt_ack == 0 && bus.blk_ack == 0, "rst_acks",
          int'({bus.txt_ack, bus.blk_ack}), 0);
      chk(bus.pix_x == 0 && bus.pix_y == 0 && bus.pix_color == 0, "rst_pix",
          int'({bus.pix_x, bus.pix_y, bus.pix_color}), 0);

      // Tie after reset: block, then text, then block again
      set_blk(1, 1, 1, 1, 2);
      set_txt(8'h00, 1, 0, 0, 1);
      push(1, 1, 2);
      bus.blk_req = 1'b1;
      bus.txt_req = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         got = bus.blk_ack | bus.txt_ack;
      end
      chk(bus.blk_ack && !bus.txt_ack, "tie_first_blk",
          int'({bus.blk_ack, bus.txt_ack}), 2);
      bus.blk_req = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = bus.txt_ack;
      end
      chk(got, "tie_second_txt", int'(got), 1);
      bus.txt_req = 1'b0;
      wait_idle("tie_txt");
      push(1, 1, 2);
      bus.blk_req = 1'b1;
      bus.txt_req = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         got = bus.blk_ack | bus.txt_ack;
      end
      chk(bus.blk_ack && !bus.txt_ack, "tie_third_blk",
          int'({bus.blk_ack, bus.txt_ack}), 2);
      bus.blk_req = 1'b0;
      bus.txt_req = 1'b0;
      wait_idle("tie_blk");
      @(negedge clock);
      chk(sb.size() == 0, "tie_drain", sb.size(), 0);

      // Basic rect
      set_blk(10, 5, 3, 2, 4);
      for (int y = 5; y < 7; y++)
         for (int x = 10; x < 13; x++) push(x, y, 4);
      run(1, 6, "rect");

      // Right-edge clip
      set_blk(158, 3, 4, 1, 1);
      push(158, 3, 1);
      push(159, 3, 1);
      run(1, 4, "clip_x");

      // Bottom-edge clip
      set_blk(0, 118, 1, 4, 2);
      push(0, 118, 2);
      push(0, 119, 2);
      run(1, 4, "clip_y");

      // Zero-width rect
      set_blk(5, 5, 0, 2, 1);
      run(1, 1, "rect_w0");

      // Glyph 0x81 row at size 2
      set_txt(8'h41, 2, 0, 0, 5);
      push(0, 0, 5);
      push(1, 0, 5);
      push(0, 1, 5);
      push(1, 1, 5);
      push(14, 0, 5);
      push(15, 0, 5);
      push(14, 1, 5);
      push(15, 1, 5);
      run(0, 272, "glyph_s2");

      // Size 0 behaves as size 1
      set_txt(8'h41, 0, 100, 100, 7);
      push(100, 100, 7);
      push(107, 100, 7);
      run(0, 80, "glyph_s0");

      // Random backpressure on a rect
      set_blk(20, 30, 4, 3, 6);
      for (int y = 30; y < 33; y++)
         for (int x = 20; x < 24; x++) push(x, y, 6);
      rand_ready = 1;
      run(1, -1, "rect_stall");
      rand_ready = 0;
      @(negedge clock);

      // Reset mid-glyph, then pending text served from row 0
      set_txt(8'h42, 1, 50, 50, 3);
      mon_on = 0;
      bus.txt_req = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         got = bus.txt_ack;
      end
      bus.txt_req = 1'b0;
      chk(got, "rst_pre_ack", int'(got), 1);
      repeat (25) @(negedge clock);
      chk(bus.pix_valid == 1, "rst_pre_valid", int'(bus.pix_valid), 1);
      bus.txt_req = 1'b1;
      @(posedge clock);
      #3 resetn = 1'b0;
      #1;
      chk(bus.pix_valid == 0, "rst_mid_valid", int'(bus.pix_valid), 0);
      chk(bus.busy == 0, "rst_mid_busy", int'(bus.busy), 0);
      chk(bus.txt_ack == 0 && bus.blk_ack == 0, "rst_mid_acks",
          int'({bus.txt_ack, bus.blk_ack}), 0);
      repeat (2) @(negedge clock);
      sb.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) push(50 + c, 50 + r, 3);
      mon_on = 1;
      @(posedge clock);
      #3 resetn = 1'b1;
      run(0, 80, "glyph_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
